// File: rtl/pool_fc_flatten.sv
// Flatten bridge from the last pool layer to the first fc layer.
// Serialises one pooled pixel vector per handshake into the fc ibuf in CHW order.
module pool_fc_flatten #(
  parameter int input_channels = 16,
  parameter int img_width      = 4,
  parameter int datatype_size  = 8,
  parameter int output_size    = input_channels * img_width * img_width
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_valid,
  input  logic [input_channels-1:0][datatype_size-1:0]  i_data,
  output logic                                          o_busy,
  output logic                                          o_ibuf_we,
  output logic [datatype_size-1:0]                      o_ibuf_wr_data,
  output logic [$clog2(output_size)-1:0]                o_ibuf_addr,
  output logic                                          o_start,
  input  logic                                          i_fc_busy
);

  localparam int P  = img_width * img_width;
  localparam int AW = $clog2(output_size);
  localparam int CW = (input_channels > 1) ? $clog2(input_channels) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_SERIAL,
    S_WAIT_FC,
    S_START,
    S_DRAIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] ch_cnt, ch_n;
  logic [PW-1:0] pix_cnt, pix_n;
  logic [input_channels-1:0][datatype_size-1:0] hold, hold_n;

  logic                     busy_n;
  logic                     we_n;
  logic                     start_n;
  logic [datatype_size-1:0] data_n;
  logic [AW-1:0]            addr_n;

  always_comb begin
    state_n = state;
    ch_n    = ch_cnt;
    pix_n   = pix_cnt;
    hold_n  = hold;
    unique case (state)
      S_ACCEPT: begin
        if (i_valid) begin
          hold_n  = i_data;
          ch_n    = '0;
          state_n = S_SERIAL;
        end
      end
      S_SERIAL: begin
        if (ch_cnt == CW'(input_channels - 1)) begin
          ch_n = '0;
          if (pix_cnt == PW'(P - 1)) begin
            state_n = S_WAIT_FC;
          end else begin
            pix_n   = pix_cnt + 1'b1;
            state_n = S_ACCEPT;
          end
        end else begin
          ch_n = ch_cnt + 1'b1;
        end
      end
      S_WAIT_FC: begin
        if (!i_fc_busy) state_n = S_START;
      end
      S_START: begin
        pix_n   = '0;
        state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_fc_busy) state_n = S_ACCEPT;
      end
      default: state_n = S_ACCEPT;
    endcase
  end

  // Outputs are registered from the next-state view so they line up
  // with the state they describe.
  always_comb begin
    busy_n  = (state_n != S_ACCEPT);
    we_n    = (state_n == S_SERIAL);
    start_n = (state_n == S_START);
    data_n  = '0;
    addr_n  = '0;
    if (we_n) begin
      data_n = hold_n[ch_n];
      addr_n = AW'(ch_n) * AW'(P) + AW'(pix_n);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_ACCEPT;
      ch_cnt         <= '0;
      pix_cnt        <= '0;
      hold           <= '0;
      o_busy         <= 1'b0;
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_start        <= 1'b0;
    end else begin
      state          <= state_n;
      ch_cnt         <= ch_n;
      pix_cnt        <= pix_n;
      hold           <= hold_n;
      o_busy         <= busy_n;
      o_ibuf_we      <= we_n;
      o_ibuf_wr_data <= data_n;
      o_ibuf_addr    <= addr_n;
      o_start        <= start_n;
    end
  end

endmodule

// File: tb/tb_pool_fc_flatten.sv
// Directed bench for pool_fc_flatten.
// Pixel data is c*16+p so every written element equals its ibuf address.
module tb_pool_fc_flatten;

  localparam int C  = 16;
  localparam int P  = 16;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_fc_busy = 1'b0;
  logic [C-1:0][DW-1:0] i_data = '0;
  logic o_busy, o_ibuf_we, o_start;
  logic [DW-1:0] o_ibuf_wr_data;
  logic [AW-1:0] o_ibuf_addr;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_cnt = 0, data_err = 0, dup_cnt = 0, start_cnt = 0;
  int last_we_cyc = 0, start_cyc = 0;
  int epoch = 1;
  int seen [256];

  always #5 clk = ~clk;

  pool_fc_flatten dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_busy(o_busy),
    .o_ibuf_we(o_ibuf_we),
    .o_ibuf_wr_data(o_ibuf_wr_data),
    .o_ibuf_addr(o_ibuf_addr),
    .o_start(o_start),
    .i_fc_busy(i_fc_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_ibuf_we === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      last_we_cyc <= cyc;
      if (o_ibuf_wr_data !== o_ibuf_addr) data_err <= data_err + 1;
      if (seen[o_ibuf_addr] == epoch) dup_cnt <= dup_cnt + 1;
      seen[o_ibuf_addr] <= epoch;
    end
    if (o_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int p);
    for (int c = 0; c < C; c++) i_data[c] = DW'(c * 16 + p);
  endtask

  task automatic send_vec(input int p, output int acc);
    int n = 0;
    while (o_busy && n < 300) begin
      tick();
      n++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL send_vec timeout: o_busy=%b, required 0", o_busy);
    end
    set_pix(p);
    i_valid = 1'b1;
    acc = cyc;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_start(input int s0, input int lim);
    int n = 0;
    while (start_cnt == s0 && n < lim) begin
      tick();
      n++;
    end
    if (start_cnt == s0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: starts=%0d, required %0d", start_cnt - s0, 1);
    end
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_fc_busy = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    checks++;
    if (o_ibuf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", o_ibuf_we); end
    checks++;
    if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, required 0", o_start); end
    checks++;
    if (o_ibuf_addr !== '0 || o_ibuf_wr_data !== '0) begin
      errors++;
      $display("FAIL rst_addr_data: got %h/%h, required 00/00", o_ibuf_addr, o_ibuf_wr_data);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", o_busy); end
  endtask

  task automatic test_full_image();
    int a, w0, d0, u0, s0;
    epoch++;
    w0 = wr_cnt; d0 = data_err; u0 = dup_cnt; s0 = start_cnt;
    for (int p = 0; p < P; p++) send_vec(p, a);
    wait_start(s0, 40);
    repeat (5) tick();
    checks++;
    if (wr_cnt - w0 != 256) begin errors++; $display("FAIL full_writes: got %0d, required 256", wr_cnt - w0); end
    checks++;
    if (data_err != d0) begin errors++; $display("FAIL full_addr_eq_data: %0d bad, required 0", data_err - d0); end
    checks++;
    if (dup_cnt != u0) begin errors++; $display("FAIL full_dup: %0d dups, required 0", dup_cnt - u0); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL full_starts: got %0d, required 1", start_cnt - s0); end
    checks++;
    if (start_cyc - last_we_cyc != 2) begin
      errors++;
      $display("FAIL full_start_lat: got %0d, required 2", start_cyc - last_we_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int p, last_acc, lp, seq_err, iv_err, w0, u0, s0;
    p = 0; last_acc = -100; lp = 0; seq_err = 0; iv_err = 0;
    epoch++;
    w0 = wr_cnt; u0 = dup_cnt; s0 = start_cnt;
    set_pix(0);
    i_valid = 1'b1;
    for (int n = 0; n < 400 && !(p == P && cyc > last_acc + 16); n++) begin
      if (cyc > last_acc && cyc <= last_acc + 16) begin
        if (o_ibuf_we !== 1'b1 || int'(o_ibuf_addr) != (cyc - last_acc - 1) * 16 + lp) seq_err++;
      end
      if (p < P && !o_busy) begin
        if (p > 0 && cyc - last_acc != 17) iv_err++;
        last_acc = cyc;
        lp = p;
        p++;
        tick();
        if (p < P) set_pix(p);
        else i_valid = 1'b0;
      end else begin
        tick();
      end
    end
    i_valid = 1'b0;
    wait_start(s0, 40);
    repeat (3) tick();
    checks++;
    if (p != P) begin errors++; $display("FAIL b2b_accepts: got %0d, required %0d", p, P); end
    checks++;
    if (iv_err != 0) begin errors++; $display("FAIL b2b_interval: %0d off, required 0", iv_err); end
    checks++;
    if (seq_err != 0) begin errors++; $display("FAIL b2b_seq: %0d bad cycles, required 0", seq_err); end
    checks++;
    if (wr_cnt - w0 != 256 || dup_cnt != u0) begin
      errors++;
      $display("FAIL b2b_writes: got %0d/%0d dups, required 256/0", wr_cnt - w0, dup_cnt - u0);
    end
  endtask

  task automatic test_valid_while_busy();
    int a, w0, d0, u0, s0, busy_err;
    epoch++;
    busy_err = 0;
    w0 = wr_cnt; d0 = data_err; u0 = dup_cnt; s0 = start_cnt;
    for (int p = 0; p < P; p++) begin
      send_vec(p, a);
      repeat (3) tick();
      for (int c = 0; c < C; c++) i_data[c] = 8'hA5;
      i_valid = 1'b1;
      repeat (3) begin
        if (o_busy !== 1'b1) busy_err++;
        tick();
      end
      i_valid = 1'b0;
    end
    wait_start(s0, 40);
    repeat (3) tick();
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL vwb_busy: %0d idle, required 0", busy_err); end
    checks++;
    if (wr_cnt - w0 != 256) begin errors++; $display("FAIL vwb_writes: got %0d, required 256", wr_cnt - w0); end
    checks++;
    if (data_err != d0 || dup_cnt != u0) begin
      errors++;
      $display("FAIL vwb_data: %0d bad/%0d dups, required 0/0", data_err - d0, dup_cnt - u0);
    end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL vwb_starts: got %0d, required 1", start_cnt - s0); end
  endtask

  task automatic test_fc_busy_end();
    int a, w0, s0, hold_err, busy_err, fall;
    epoch++;
    hold_err = 0; busy_err = 0;
    w0 = wr_cnt; s0 = start_cnt;
    for (int p = 0; p < P; p++) send_vec(p, a);
    i_fc_busy = 1'b1;
    // busy stays high for the 30 cycles following the last write at a+16
    while (cyc < a + 47) begin
      if (o_start !== 1'b0) hold_err++;
      if (o_busy !== 1'b1) busy_err++;
      tick();
    end
    i_fc_busy = 1'b0;
    fall = cyc;
    wait_start(s0, 20);
    repeat (3) tick();
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL fcb_hold: %0d early starts, required 0", hold_err); end
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL fcb_busy: %0d idle, required 0", busy_err); end
    checks++;
    if (last_we_cyc != a + 16 || wr_cnt - w0 != 256) begin
      errors++;
      $display("FAIL fcb_writes: last=%0d n=%0d, required %0d/256", last_we_cyc, wr_cnt - w0, a + 16);
    end
    // WAIT_FC sees busy low in cycle fall, START follows as the second cycle
    checks++;
    if (start_cyc != fall + 1 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL fcb_start: cyc=%0d n=%0d, required %0d/1", start_cyc, start_cnt - s0, fall + 1);
    end
  endtask

  task automatic test_drain();
    int a, n, busy_err, we_err;
    epoch++;
    busy_err = 0; we_err = 0; n = 0;
    for (int p = 0; p < P; p++) send_vec(p, a);
    while (o_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (o_start !== 1'b1) begin errors++; $display("FAIL drain_start: got %b, required 1", o_start); end
    epoch++;
    set_pix(0);
    i_valid = 1'b1;
    tick();
    i_fc_busy = 1'b1;
    repeat (100) begin
      if (o_busy !== 1'b1) busy_err++;
      if (o_ibuf_we !== 1'b0) we_err++;
      tick();
    end
    i_fc_busy = 1'b0;
    checks++;
    if (busy_err != 0 || we_err != 0) begin
      errors++;
      $display("FAIL drain_hold: %0d idle/%0d writes, required 0/0", busy_err, we_err);
    end
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL drain_last: got %b, required 1", o_busy); end
    tick();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL drain_exit: got %b, required 0", o_busy); end
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_ibuf_we !== 1'b1 || o_ibuf_addr !== 8'd0) begin
      errors++;
      $display("FAIL drain_first_wr: we=%b addr=%0d, required 1/0", o_ibuf_we, o_ibuf_addr);
    end
  endtask

  task automatic test_reset_mid();
    int a, s0, w0, d0, seq_err;
    seq_err = 0;
    do_reset();
    epoch++;
    for (int p = 0; p < 8; p++) send_vec(p, a);
    repeat (5) tick();
    checks++;
    if (o_ibuf_we !== 1'b1 || o_ibuf_addr !== 8'd87) begin
      errors++;
      $display("FAIL mid_pos: we=%b addr=%0d, required 1/87", o_ibuf_we, o_ibuf_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_ibuf_we, o_start, o_ibuf_addr, o_ibuf_wr_data} !== '0) begin
      errors++;
      $display("FAIL mid_rst_out: busy=%b we=%b start=%b addr=%0d data=%0d, required all 0",
               o_busy, o_ibuf_we, o_start, o_ibuf_addr, o_ibuf_wr_data);
    end
    tick();
    rst = 1'b1;
    tick();
    epoch++;
    s0 = start_cnt; w0 = wr_cnt; d0 = data_err;
    send_vec(0, a);
    for (int c = 0; c < C; c++) begin
      if (o_ibuf_we !== 1'b1 || int'(o_ibuf_addr) != c * 16) seq_err++;
      tick();
    end
    checks++;
    if (seq_err != 0) begin errors++; $display("FAIL mid_addr_seq: %0d bad, required 0", seq_err); end
    for (int p = 1; p < P - 1; p++) send_vec(p, a);
    repeat (20) tick();
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL mid_early_start: got %0d, required 0", start_cnt - s0); end
    send_vec(P - 1, a);
    wait_start(s0, 40);
    repeat (3) tick();
    checks++;
    if (start_cnt - s0 != 1 || wr_cnt - w0 != 256 || data_err != d0) begin
      errors++;
      $display("FAIL mid_new_image: starts=%0d writes=%0d bad=%0d, required 1/256/0",
               start_cnt - s0, wr_cnt - w0, data_err - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) seen[i] = 0;
    test_reset();
    test_full_image();
    test_back_to_back();
    test_valid_while_busy();
    test_fc_busy_end();
    test_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
